pll_lock_sequencer: RTL and testbench

PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

---
 rtl/pll_seq_pkg.sv | 15 +
 rtl/pll_sync2.sv | 24 ++
 rtl/pll_lock_sequencer.sv | 158 +++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL lock sequencer.
package pll_seq_pkg;

  localparam int unsigned STATE_W    = 3;
  localparam int unsigned LOSS_CNT_W = 8;

  typedef enum logic [STATE_W-1:0] {
    RESET_HOLD = 3'd0,
    WAIT_LOCK  = 3'd1,
    STABLE     = 3'd2,
    RUN        = 3'd3,
    FAULT      = 3'd4
  } pll_state_e;

endpackage

// File: rtl/pll_sync2.sv
// Two-flop synchronizer for a single asynchronous level.
module pll_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock qualification sequencer with saturating lock-loss count.
// Define PLL_SEQ_WATCHDOG_EN to add the lock watchdog, retry limit and FAULT state.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_CYCLES     = 16,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  input  logic                  restart,
  input  logic                  pll_locked,
  output logic                  pll_rst,
  output logic                  sys_ready,
  output logic                  fault,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt,
  output logic [STATE_W-1:0]    state
);

  localparam int unsigned RST_CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int unsigned STB_CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

  if (RST_CYCLES < 2 || STABLE_CYCLES < 1 || TIMEOUT_CYCLES < 1 || MAX_RETRY < 1)
  begin : g_param_check
    $error("pll_lock_sequencer: illegal parameter value");
  end

  logic locked_s;

  pll_sync2 u_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  pll_state_e            state_q, state_d;
  logic [RST_CNT_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic [STB_CNT_W-1:0]  stb_cnt_q, stb_cnt_d;
  logic [LOSS_CNT_W-1:0] loss_q, loss_d;
  logic                  pll_rst_q, pll_rst_d;
  logic                  sys_ready_q, sys_ready_d;

`ifdef PLL_SEQ_WATCHDOG_EN
  localparam int unsigned TMR_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);

  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [RETRY_W-1:0] retry_q, retry_d, retry_inc;
  logic               fault_q, fault_d;
`endif

  // Next-state and registered-output logic; restart overrides everything.
  always_comb begin
    state_d   = state_q;
    rst_cnt_d = '0;
    stb_cnt_d = '0;
    loss_d    = loss_q;
`ifdef PLL_SEQ_WATCHDOG_EN
    tmr_d     = '0;
    retry_d   = retry_q;
    retry_inc = (retry_q == RETRY_W'(MAX_RETRY)) ? retry_q : retry_q + RETRY_W'(1);
`endif

    if (restart) begin
      state_d = RESET_HOLD;
`ifdef PLL_SEQ_WATCHDOG_EN
      retry_d = '0;
`endif
    end else begin
      case (state_q)
        RESET_HOLD: begin
          if (rst_cnt_q == RST_CNT_W'(RST_CYCLES - 1)) state_d = WAIT_LOCK;
          else rst_cnt_d = rst_cnt_q + RST_CNT_W'(1);
        end
        WAIT_LOCK: begin
          if (locked_s) state_d = STABLE;
        end
        STABLE: begin
          if (!locked_s) state_d = WAIT_LOCK;
          else if (stb_cnt_q == STB_CNT_W'(STABLE_CYCLES - 1)) state_d = RUN;
          else stb_cnt_d = stb_cnt_q + STB_CNT_W'(1);
        end
        RUN: begin
          if (!locked_s) begin
            state_d = RESET_HOLD;
            if (loss_q != '1) loss_d = loss_q + LOSS_CNT_W'(1);
          end
        end
        FAULT: ;
        default: state_d = RESET_HOLD;
      endcase

`ifdef PLL_SEQ_WATCHDOG_EN
      // Watchdog spans WAIT_LOCK and STABLE; a timeout outranks lock progress.
      if (state_q == WAIT_LOCK || state_q == STABLE) begin
        if (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          retry_d = retry_inc;
          state_d = (retry_inc < RETRY_W'(MAX_RETRY)) ? RESET_HOLD : FAULT;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      if (state_d == RUN) retry_d = '0;
`endif
    end

    pll_rst_d   = (state_d == RESET_HOLD) || (state_d == FAULT);
    sys_ready_d = (state_d == RUN);
`ifdef PLL_SEQ_WATCHDOG_EN
    fault_d     = (state_d == FAULT);
`endif
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RESET_HOLD;
      rst_cnt_q   <= '0;
      stb_cnt_q   <= '0;
      loss_q      <= '0;
      pll_rst_q   <= 1'b1;
      sys_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      stb_cnt_q   <= stb_cnt_d;
      loss_q      <= loss_d;
      pll_rst_q   <= pll_rst_d;
      sys_ready_q <= sys_ready_d;
    end
  end

`ifdef PLL_SEQ_WATCHDOG_EN
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_q   <= '0;
      retry_q <= '0;
      fault_q <= 1'b0;
    end else begin
      tmr_q   <= tmr_d;
      retry_q <= retry_d;
      fault_q <= fault_d;
    end
  end

  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  assign pll_rst       = pll_rst_q;
  assign sys_ready     = sys_ready_q;
  assign lock_loss_cnt = loss_q;
  assign state         = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Randomized and directed bench for pll_lock_sequencer against a cycle-level behavioural model.
module tb_pll_lock_sequencer;

  localparam int unsigned RST_C   = 4;
  localparam int unsigned STB_C   = 8;
  localparam int unsigned TMO_C   = 64;
  localparam int unsigned RETRY_C = 2;

  // Debug state codes in the order the states are listed for the block.
  localparam int P_HOLD = 0, P_WAIT = 1, P_STABLE = 2, P_RUN = 3, P_FAULT = 4;

  logic       refclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       restart = 1'b0;
  logic       pll_locked = 1'b0;
  logic       pll_rst, sys_ready, fault;
  logic [7:0] lock_loss_cnt;
  logic [2:0] state;

  int n_vec = 0;
  int n_miss = 0;

  pll_lock_sequencer #(
    .RST_CYCLES     (RST_C),
    .STABLE_CYCLES  (STB_C),
    .TIMEOUT_CYCLES (TMO_C),
    .MAX_RETRY      (RETRY_C)
  ) dut (
    .refclk        (refclk),
    .rst_n         (rst_n),
    .restart       (restart),
    .pll_locked    (pll_locked),
    .pll_rst       (pll_rst),
    .sys_ready     (sys_ready),
    .fault         (fault),
    .lock_loss_cnt (lock_loss_cnt),
    .state         (state)
  );

  always #5 refclk = ~refclk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: phase plus elapsed-cycle bookkeeping, stepped once per edge.
  int m_phase = 0;
  int m_hold = 0;
  int m_good = 0;
  int m_loss = 0;
  bit m_sync0 = 1'b0;
  bit m_sync1 = 1'b0;
`ifdef PLL_SEQ_WATCHDOG_EN
  int m_wd = 0;
  int m_tries = 0;
`endif

  always @(posedge refclk or negedge rst_n) begin
    bit ls;
    int prev;
    if (!rst_n) begin
      m_phase = P_HOLD; m_hold = 0; m_good = 0; m_loss = 0;
      m_sync0 = 1'b0; m_sync1 = 1'b0;
`ifdef PLL_SEQ_WATCHDOG_EN
      m_wd = 0; m_tries = 0;
`endif
    end else begin
      ls = m_sync1;
      m_sync1 = m_sync0;
      m_sync0 = pll_locked;
      prev = m_phase;
      if (restart) begin
        m_phase = P_HOLD; m_hold = 0;
`ifdef PLL_SEQ_WATCHDOG_EN
        m_tries = 0;
`endif
      end else begin
        case (prev)
          P_HOLD: begin
            m_hold++;
            if (m_hold == RST_C) begin
              m_phase = P_WAIT;
`ifdef PLL_SEQ_WATCHDOG_EN
              m_wd = 0;
`endif
            end
          end
          P_WAIT: if (ls) begin m_phase = P_STABLE; m_good = 0; end
          P_STABLE: begin
            if (!ls) m_phase = P_WAIT;
            else begin
              m_good++;
              if (m_good == STB_C) m_phase = P_RUN;
            end
          end
          P_RUN: if (!ls) begin
            m_phase = P_HOLD; m_hold = 0;
            if (m_loss < 255) m_loss++;
          end
          default: ;
        endcase
`ifdef PLL_SEQ_WATCHDOG_EN
        if (prev == P_WAIT || prev == P_STABLE) begin
          m_wd++;
          if (m_wd == TMO_C) begin
            if (m_tries < RETRY_C) m_tries++;
            m_phase = (m_tries < RETRY_C) ? P_HOLD : P_FAULT;
            m_hold = 0;
          end
        end
        if (m_phase == P_RUN) m_tries = 0;
`endif
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge refclk) begin
    chk("model_state", 32'(state), 32'(m_phase));
    chk("model_pll_rst", 32'(pll_rst), 32'(m_phase == P_HOLD || m_phase == P_FAULT));
    chk("model_sys_ready", 32'(sys_ready), 32'(m_phase == P_RUN));
    chk("model_fault", 32'(fault), 32'(m_phase == P_FAULT));
    chk("model_loss_cnt", 32'(lock_loss_cnt), 32'(m_loss));
  end

  task automatic check_reset_values(input string tag);
    chk({tag, "_state"}, 32'(state), 0);
    chk({tag, "_pll_rst"}, 32'(pll_rst), 1);
    chk({tag, "_sys_ready"}, 32'(sys_ready), 0);
    chk({tag, "_fault"}, 32'(fault), 0);
    chk({tag, "_loss_cnt"}, 32'(lock_loss_cnt), 0);
  endtask

  task automatic do_reset();
    @(negedge refclk);
    rst_n = 1'b0; pll_locked = 1'b0; restart = 1'b0;
    repeat (2) @(negedge refclk);
    check_reset_values("in_reset");
    rst_n = 1'b1;
  endtask

  task automatic wait_state(input int code, input int max, input string nm);
    int c = 0;
    while (state !== 3'(code) && c < max) begin
      @(negedge refclk);
      c++;
    end
    chk(nm, 32'(state), 32'(code));
  endtask

  task automatic wait_ready(input int max, input string nm);
    int c = 0;
    while (sys_ready !== 1'b1 && c < max) begin
      @(negedge refclk);
      c++;
    end
    chk(nm, 32'(sys_ready), 1);
  endtask

  initial begin
    int n;
    int prev_loss;
    int run_left;

    // Nominal bring-up.
    do_reset();
    n = 0;
    do begin @(negedge refclk); n++; end while (pll_rst === 1'b1 && n < 20);
    chk("rst_pulse_edges", 32'(n), 32'(RST_C));
    repeat (10 - RST_C) @(negedge refclk);
    pll_locked = 1'b1;
    n = 0;
    do begin @(negedge refclk); n++; end while (sys_ready !== 1'b1 && n < 40);
    chk("lock_to_ready_edges", 32'(n), 32'(1 + 2 + STB_C));
    chk("nominal_loss_cnt", 32'(lock_loss_cnt), 0);

    // Lock glitch during STABLE.
    do_reset();
    repeat (10) @(negedge refclk);
    pll_locked = 1'b1;
    wait_state(P_STABLE, 10, "glitch_enter_stable");
    repeat (5) @(negedge refclk);
    pll_locked = 1'b0;
    repeat (3) @(negedge refclk);
    chk("glitch_back_to_wait", 32'(state), 32'(P_WAIT));
    chk("glitch_not_ready", 32'(sys_ready), 0);
    pll_locked = 1'b1;
    n = 0;
    do begin @(negedge refclk); n++; end while (sys_ready !== 1'b1 && n < 40);
    chk("glitch_restore_to_ready", 32'(n), 32'(1 + 2 + STB_C));

    // One ordinary loss, then restart coincident with a second loss.
    pll_locked = 1'b0;
    repeat (3) @(negedge refclk);
    pll_locked = 1'b1;
    wait_ready(40, "relock_after_loss");
    chk("single_loss_cnt", 32'(lock_loss_cnt), 1);
    prev_loss = int'(lock_loss_cnt);
    pll_locked = 1'b0;
    repeat (2) @(negedge refclk);
    restart = 1'b1;
    @(negedge refclk);
    restart = 1'b0;
    chk("restart_wins_state", 32'(state), 32'(P_HOLD));
    chk("restart_wins_loss_cnt", 32'(lock_loss_cnt), 32'(prev_loss));
    pll_locked = 1'b1;
    repeat (20) @(negedge refclk);

    // Randomized lock activity with occasional restarts.
    do_reset();
    run_left = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge refclk);
      restart = ($urandom_range(0, 99) == 0);
      if (run_left <= 0) begin
        pll_locked = ~pll_locked;
        run_left = pll_locked ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 90));
      end
      run_left--;
    end
    restart = 1'b0;

    // Asynchronous reset in the middle of STABLE.
    do_reset();
    repeat (6) @(negedge refclk);
    pll_locked = 1'b1;
    wait_ready(40, "pre_abort_ready");
    pll_locked = 1'b0;
    repeat (2) @(negedge refclk);
    pll_locked = 1'b1;
    wait_state(P_STABLE, 30, "pre_abort_stable");
    chk("pre_abort_loss_cnt", 32'(lock_loss_cnt), 1);
    @(negedge refclk);
    #2 rst_n = 1'b0;
    #1 check_reset_values("async_abort");
    repeat (2) @(negedge refclk);

    // Repeated loss in RUN up to saturation.
    do_reset();
    repeat (6) @(negedge refclk);
    pll_locked = 1'b1;
    wait_ready(40, "sat_initial_ready");
    for (int i = 0; i < 300; i++) begin
      int lo_len, drop_at, hi;
      lo_len = int'($urandom_range(1, 5));
      drop_at = 0;
      hi = 0;
      pll_locked = 1'b0;
      for (int c = 1; c <= 40; c++) begin
        @(negedge refclk);
        if (c == lo_len) pll_locked = 1'b1;
        if (sys_ready === 1'b0 && drop_at == 0) drop_at = c;
        if (pll_rst === 1'b1) hi++;
      end
      chk("loss_drop_within_3", 32'(drop_at >= 1 && drop_at <= 3), 1);
      chk("loss_rst_pulse", 32'(hi), 32'(RST_C));
      chk("loss_recovered", 32'(sys_ready), 1);
      chk("loss_cnt", 32'(lock_loss_cnt), 32'((i + 1 > 255) ? 255 : i + 1));
    end

`ifdef PLL_SEQ_WATCHDOG_EN
    // Watchdog: lock never arrives.
    begin
      int falls;
      logic last_rst;
      do_reset();
      n = 0; falls = 0; last_rst = 1'b1;
      while (fault !== 1'b1 && n < 400) begin
        @(negedge refclk);
        n++;
        if (last_rst === 1'b1 && pll_rst === 1'b0) falls++;
        last_rst = pll_rst;
      end
      chk("wd_fault_edge", 32'(n), 32'(RETRY_C * (RST_C + TMO_C)));
      chk("wd_rst_pulses", 32'(falls), 32'(RETRY_C));
      repeat (20) @(negedge refclk);
      chk("wd_fault_held", 32'(fault), 1);
      chk("wd_pll_rst_held", 32'(pll_rst), 1);
      chk("wd_not_ready", 32'(sys_ready), 0);
      restart = 1'b1;
      @(negedge refclk);
      restart = 1'b0;
      chk("wd_restart_clears_fault", 32'(fault), 0);
      chk("wd_restart_state", 32'(state), 32'(P_HOLD));
      pll_locked = 1'b1;
      wait_ready(40, "wd_rerun_ready");
    end
`else
    do_reset();
    repeat (200) @(negedge refclk);
    chk("nowd_waits_forever", 32'(state), 32'(P_WAIT));
    chk("nowd_fault_low", 32'(fault), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
